// File: rtl/mat_stream_out_if.sv
// Handshake/bus bundle between the matrix producer, the serializer and the
// element consumer. Elements are IEEE-754 doubles carried as raw 64-bit words.
interface mat_stream_out_if #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8
);
    localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

    logic                                 mat_valid;
    logic [SIZE_A-1:0][SIZE_B-1:0][63:0]  mat_in;
    logic [63:0]                          out_data;
    logic [RW-1:0]                        out_row;
    logic [CW-1:0]                        out_col;
    logic                                 out_valid;
    logic                                 out_ready;
    logic                                 out_last;
    logic                                 busy;
    logic                                 done;
    logic                                 overrun;

    // Producer/consumer side: drives the matrix and the ready.
    modport master (
        output mat_valid, mat_in, out_ready,
        input  out_data, out_row, out_col, out_valid, out_last, busy, done, overrun
    );

    // Serializer side.
    modport slave (
        input  mat_valid, mat_in, out_ready,
        output out_data, out_row, out_col, out_valid, out_last, busy, done, overrun
    );
endinterface

// File: rtl/mat_stream_out.sv
// Matrix output serializer: captures a full SIZE_A x SIZE_B matrix on the
// rising edge of mat_valid and streams it row-major, one element per
// valid/ready transfer, tagged with row/column indices.
module mat_stream_out #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8
) (
    input  logic              clk,
    input  logic              rst,
    mat_stream_out_if.slave   strm
);
    localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                               state_q, state_d;
    logic [RW-1:0]                        row_q, row_d;
    logic [CW-1:0]                        col_q, col_d;
    logic                                 mat_valid_q;
    logic                                 done_q, done_d;
    logic                                 overrun_q, overrun_d;
    logic                                 load;
    logic [SIZE_A-1:0][SIZE_B-1:0][63:0]  mat_q;

    logic capture, at_col_end, at_last, streaming;

    assign streaming  = (state_q == STREAM);
    assign capture    = strm.mat_valid & ~mat_valid_q;
    assign at_col_end = (col_q == CW'(SIZE_B - 1));
    assign at_last    = at_col_end & (row_q == RW'(SIZE_A - 1));

    // Next-state: capture in IDLE, walk row-major indices on each transfer in STREAM.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // A new matrix while streaming is flagged but never disturbs the buffer.
                if (capture) overrun_d = 1'b1;
                if (strm.out_ready) begin
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (at_col_end) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset overrides every event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            mat_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mat_valid_q <= strm.mat_valid;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Matrix buffer needs no reset: out_data is forced to zero outside STREAM.
    always_ff @(posedge clk) begin
        if (load && !rst) mat_q <= strm.mat_in;
    end

    assign strm.out_valid = streaming;
    assign strm.busy      = streaming;
    assign strm.out_last  = streaming & at_last;
    assign strm.out_row   = row_q;
    assign strm.out_col   = col_q;
    assign strm.out_data  = streaming ? mat_q[row_q][col_q] : 64'd0;
    assign strm.done      = done_q;
    assign strm.overrun   = overrun_q;
endmodule

// File: tb/tb_mat_stream_out.sv
// Randomized bench for mat_stream_out: a 2x3 instance checked every cycle
// against a linear-index reference model, plus a directed 1x1 instance.
module tb_mat_stream_out;
    localparam int A = 2;
    localparam int B = 3;
    localparam int N = A * B;

    logic clk = 1'b0;
    logic rst;
    logic rst1;
    always #5 clk = ~clk;

    mat_stream_out_if #(.SIZE_A(A), .SIZE_B(B)) s0();
    mat_stream_out_if #(.SIZE_A(1), .SIZE_B(1)) s1();

    mat_stream_out #(.SIZE_A(A), .SIZE_B(B)) u_dut (.clk(clk), .rst(rst), .strm(s0.slave));
    mat_stream_out #(.SIZE_A(1), .SIZE_B(1)) u_dut1 (.clk(clk), .rst(rst1), .strm(s1.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one flat element list plus a linear position k.
    bit          m_busy = 0, m_done = 0, m_ovr = 0, m_prev = 0;
    int          m_k = 0;
    logic [63:0] m_mat [N];

    task automatic set_mat(input int base);
        for (int i = 0; i < A; i++)
            for (int j = 0; j < B; j++)
                s0.mat_in[i][j] = $realtobits(real'(base + 10 * i + j));
    endtask

    task automatic rand_mat();
        for (int i = 0; i < A; i++)
            for (int j = 0; j < B; j++)
                s0.mat_in[i][j] = {$urandom, $urandom};
    endtask

    // Drive one cycle of inputs, check outputs against the model, advance the model.
    task automatic step(input bit mv, input bit rdy, input bit r);
        bit cap;
        bit nd;
        s0.mat_valid = mv;
        s0.out_ready = rdy;
        rst          = r;
        @(negedge clk);
        chk("out_valid", s0.out_valid, m_busy);
        chk("busy",      s0.busy,      m_busy);
        chk("done",      s0.done,      m_done);
        chk("overrun",   s0.overrun,   m_ovr);
        chk("out_last",  s0.out_last,  m_busy && (m_k == N - 1));
        chk("out_row",   s0.out_row,   m_busy ? m_k / B : 0);
        chk("out_col",   s0.out_col,   m_busy ? m_k % B : 0);
        chk("out_data",  s0.out_data,  m_busy ? m_mat[m_k] : 64'd0);
        if (r) begin
            m_busy = 0; m_done = 0; m_ovr = 0; m_prev = 0; m_k = 0;
        end else begin
            cap = mv && !m_prev;
            nd  = 0;
            if (m_busy) begin
                if (cap) m_ovr = 1;
                if (rdy) begin
                    if (m_k == N - 1) begin
                        m_busy = 0;
                        nd     = 1;
                        m_k    = 0;
                    end else begin
                        m_k++;
                    end
                end
            end else if (cap) begin
                for (int e = 0; e < N; e++) m_mat[e] = s0.mat_in[e / B][e % B];
                m_busy = 1;
                m_k    = 0;
            end
            m_done = nd;
            m_prev = mv;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rst1 = 1'b1;
        s0.mat_valid = 1'b0;
        s0.out_ready = 1'b1;
        set_mat(0);
        s1.mat_valid = 1'b1;
        s1.out_ready = 1'b1;
        s1.mat_in[0][0] = $realtobits(42.5);
        @(posedge clk);
        #1;

        // Reset state
        step(0, 1, 1);
        step(0, 1, 1);

        // Single capture, no backpressure
        step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);

        // Backpressure 1,0,0,1 repeating
        step(1, 1, 0);
        for (int i = 0; i < 25; i++) step(0, (i % 4 == 0) || (i % 4 == 3), 0);

        // Level held high: one capture only, then a second rise after done
        for (int i = 0; i < 20; i++) step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);

        // Overrun: new matrix arrives mid-stream, then captured after done
        set_mat(0);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        set_mat(100);
        step(1, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        step(1, 1, 0);
        set_mat(500);
        for (int i = 0; i < 10; i++) step(0, 1, 0);

        // Reset mid-stream aborts, then a fresh stream starts at [0][0]
        set_mat(0);
        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) rand_mat();
            step($urandom_range(7) < 3, $urandom_range(2) != 0, $urandom_range(120) == 0);
        end
        for (int i = 0; i < 20; i++) step(0, 1, 0);

        // 1x1 instance: mat_valid already high as reset drops
        rst1 = 1'b0;
        @(negedge clk);
        chk("u1_valid_reset", s1.out_valid, 1'b0);
        chk("u1_busy_reset", s1.busy, 1'b0);
        @(negedge clk);
        chk("u1_valid", s1.out_valid, 1'b1);
        chk("u1_last", s1.out_last, 1'b1);
        chk("u1_data", s1.out_data, $realtobits(42.5));
        chk("u1_row", s1.out_row, 1'b0);
        chk("u1_col", s1.out_col, 1'b0);
        @(negedge clk);
        chk("u1_valid_after", s1.out_valid, 1'b0);
        chk("u1_done", s1.done, 1'b1);
        @(negedge clk);
        chk("u1_done_once", s1.done, 1'b0);
        chk("u1_valid_held", s1.out_valid, 1'b0);
        chk("u1_overrun", s1.overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mat_stream_out.md
# mat_stream_out

Output serializer downstream of the matrix scalar-divide stage. Captures a complete SIZE_A x SIZE_B matrix of `double` values on the rising edge of the upstream level-valid, then streams the elements one per transfer in row-major order over a valid/ready handshake. Each element carries its row and column indices. Feeds the post-normalisation consumers (memory writer, host link) that cannot accept a full parallel matrix.

## Interface
Parameters:
- SIZE_A, 8, number of rows (≥1)
- SIZE_B, 8, number of columns (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mat_valid  in  1  upstream matrix-ready level; may stay high for many cycles
- mat_in  in  double[SIZE_A][SIZE_B]  upstream matrix (fp_double `double`), sampled only on capture
- out_data  out  double  current element
- out_row  out  max(1,$clog2(SIZE_A))  row index of out_data
- out_col  out  max(1,$clog2(SIZE_B))  column index of out_data
- out_valid  out  1  element available
- out_ready  in  1  downstream accepts element
- out_last  out  1  high with element [SIZE_A-1][SIZE_B-1]
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse after final transfer
- overrun  out  1  sticky: a new matrix arrived while busy

## Operation
- Edge detect: register mat_valid_d (reset 0). Capture event = mat_valid & ~mat_valid_d.
- States: IDLE, STREAM.
- IDLE: on capture event, register all of mat_in into the internal buffer, clear row/col to 0, go to STREAM. Otherwise hold.
- STREAM: out_valid=1. Transfer = out_valid & out_ready. On transfer, col increments. At col=SIZE_B-1, col wraps to 0 and row increments. On transfer of [SIZE_A-1][SIZE_B-1], go to IDLE and set done for the next cycle.
- out_data = buffer[row][col]. out_data, out_row, out_col, and out_last remain stable while out_valid & ~out_ready.
- Capture event in STREAM, including the cycle of the final transfer: set overrun. The buffer is not modified and streaming continues undisturbed. overrun clears only on rst.
- mat_valid held high after a capture causes no further capture. mat_valid must fall and rise again.
- mat_in is ignored outside the capture cycle. Later changes do not affect buffered data.
- SIZE_A=1 or SIZE_B=1: the index register for a dimension of size 1 is constant 0. For SIZE_A=SIZE_B=1, out_last is high on the only element.
- Reset values: out_valid=0, out_last=0, busy=0, done=0, overrun=0, out_row=0, out_col=0, out_data=0, state=IDLE, mat_valid_d=0.
- rst during STREAM: abort immediately. Next cycle all outputs are at reset values and no done pulse is produced.
- rst has priority over every event in the same cycle.
- Because mat_valid_d resets to 0, a mat_valid already high when rst deasserts produces a capture on the first non-reset cycle.

## Timing
- Capture event sampled at edge N: out_valid=1, busy=1, element [0][0] presented from cycle N+1.
- With out_ready held high: one element per cycle. The final transfer occurs at edge N+SIZE_A·SIZE_B.
- After that final transfer, out_valid=0, busy=0, and done=1 for exactly one cycle, starting at cycle N+SIZE_A·SIZE_B+1.
- Earliest next capture: the cycle in which done is high. A capture event there is accepted without overrun.
- Backpressure adds one cycle per cycle with out_ready low. There is no combinational path from out_ready to out_valid.
- overrun rises in the cycle after the offending capture event.

## Test plan
- SIZE_A=2, SIZE_B=3, mat_in[i][j]=10i+j as doubles, out_ready=1, single mat_valid rise at edge 5 -> elements 0,1,2,10,11,12 on cycles 6–11; (row,col) sequence (0,0)…(1,2); out_last only on cycle 11; done on cycle 12; overrun=0.
- Same matrix with out_ready toggling 1,0,0,1,… -> same six values in the same order; outputs stable during stall cycles; done one cycle after the sixth transfer.
- mat_valid held high 20 cycles, then low, then high again after done -> exactly two full streams, no duplicates.
- Second mat_valid rise during element 3 with a different mat_in -> overrun=1 from the next cycle; the original values still stream; a new capture after done streams the new matrix; overrun stays 1 until rst.
- rst asserted during element 2 -> next cycle out_valid=0, busy=0, done=0, overrun=0, out_row/out_col=0. The following mat_valid rise streams from [0][0].
- SIZE_A=SIZE_B=1 with mat_valid high at rst deassertion -> capture on the first cycle; single element with out_last=1; done one cycle after its transfer.
